// File: rtl/satadd_pkg.sv
// Shared types and constants for the satadd core and its byte-stream frame controller.
// Mode encoding for satadd: bit0 selects signed operands, bit1 selects subtract.
package satadd_pkg;

    localparam int unsigned OP_W     = 12;
    localparam int unsigned MODE_W   = 2;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned EXT_W    = OP_W + 2;
    localparam int unsigned SETTLE_W = 4;

    localparam int unsigned MODE_SIGNED_BIT = 0;
    localparam int unsigned MODE_SUB_BIT    = 1;

    localparam logic [3:0] RSP_PAD = 4'b0;

    localparam logic signed [EXT_W-1:0] SAT_U_HI = EXT_W'(4095);
    localparam logic signed [EXT_W-1:0] SAT_U_LO = EXT_W'(0);
    localparam logic signed [EXT_W-1:0] SAT_S_HI = EXT_W'(2047);
    localparam logic signed [EXT_W-1:0] SAT_S_LO = EXT_W'(-2048);

    typedef enum logic [2:0] {
        ST_RX0    = 3'd0,
        ST_RX1    = 3'd1,
        ST_RX2    = 3'd2,
        ST_RX3    = 3'd3,
        ST_SETTLE = 3'd4,
        ST_TX_HI  = 3'd5,
        ST_TX_LO  = 3'd6
    } state_e;

    typedef struct packed {
        logic [MODE_W-1:0] mode;
        logic [OP_W-1:0]   a;
        logic [OP_W-1:0]   b;
    } cmd_t;

endpackage

// File: rtl/satadd.sv
// 12-bit saturating add/subtract; unsigned or signed clamp selected by mode.
module satadd
    import satadd_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    input  logic [MODE_W-1:0] mode,
    output logic [OP_W-1:0]   y
);

    logic signed [EXT_W-1:0] ext_a;
    logic signed [EXT_W-1:0] ext_b;
    logic signed [EXT_W-1:0] sum;
    logic signed [EXT_W-1:0] lim_hi;
    logic signed [EXT_W-1:0] lim_lo;

    // Two guard bits keep any add/sub of 12-bit operands exact before clamping.
    always_comb begin
        ext_a  = mode[MODE_SIGNED_BIT] ? $signed({{2{a[OP_W-1]}}, a}) : $signed({2'b00, a});
        ext_b  = mode[MODE_SIGNED_BIT] ? $signed({{2{b[OP_W-1]}}, b}) : $signed({2'b00, b});
        sum    = mode[MODE_SUB_BIT] ? (ext_a - ext_b) : (ext_a + ext_b);
        lim_hi = mode[MODE_SIGNED_BIT] ? SAT_S_HI : SAT_U_HI;
        lim_lo = mode[MODE_SIGNED_BIT] ? SAT_S_LO : SAT_U_LO;
        y      = sum[OP_W-1:0];
        if (sum > lim_hi) begin
            y = lim_hi[OP_W-1:0];
        end else if (sum < lim_lo) begin
            y = lim_lo[OP_W-1:0];
        end
    end

endmodule

// File: rtl/satadd_frame_ctrl.sv
// Byte-stream front end: collects 4-byte command frames, runs them through satadd,
// and returns the saturated result as a 2-byte response frame.
module satadd_frame_ctrl
    import satadd_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic [CNT_W-1:0] frame_cnt
);

    state_e               state_q, state_d;
    cmd_t                 cmd_q, cmd_d;
    logic [OP_W-1:0]      cap_q, cap_d;
    logic [SETTLE_W-1:0]  settle_q, settle_d;
    logic                 frame_err_q, frame_err_d;
    logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [BYTE_W-1:0]    out_data_q, out_data_d;
    logic [OP_W-1:0]      sat_y;
    logic                 in_xfer;
    logic                 out_xfer;

    satadd u_satadd (
        .a    (cmd_q.a),
        .b    (cmd_q.b),
        .mode (cmd_q.mode),
        .y    (sat_y)
    );

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cap_d       = cap_q;
        settle_d    = settle_q;
        frame_err_d = 1'b0;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            ST_RX0: begin
                if (in_xfer) begin
                    if (in_data[7:2] != 6'd0) begin
                        frame_err_d = 1'b1;
                    end else begin
                        cmd_d.mode = in_data[MODE_W-1:0];
                        state_d    = ST_RX1;
                    end
                end
            end
            ST_RX1: begin
                if (in_xfer) begin
                    cmd_d.a[OP_W-1:4] = in_data;
                    state_d           = ST_RX2;
                end
            end
            ST_RX2: begin
                if (in_xfer) begin
                    cmd_d.a[3:0]      = in_data[7:4];
                    cmd_d.b[OP_W-1:8] = in_data[3:0];
                    state_d           = ST_RX3;
                end
            end
            ST_RX3: begin
                // SETTLE spans SETTLE_CYCLES+1 cycles, so out_valid rises
                // SETTLE_CYCLES+1 edges after the byte3 handshake.
                if (in_xfer) begin
                    cmd_d.b[7:0] = in_data;
                    settle_d     = SETTLE_W'(SETTLE_CYCLES);
                    state_d      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_W'(0)) begin
                    cap_d   = sat_y;
                    state_d = ST_TX_HI;
                end else begin
                    settle_d = settle_q - SETTLE_W'(1);
                end
            end
            ST_TX_HI: begin
                if (out_xfer) begin
                    state_d = ST_TX_LO;
                end
            end
            ST_TX_LO: begin
                if (out_xfer) begin
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    state_d     = ST_RX0;
                end
            end
            default: begin
                state_d = ST_RX0;
            end
        endcase

        // Handshake flags and response byte are registered images of the next state.
        in_ready_d  = (state_d == ST_RX0) || (state_d == ST_RX1) ||
                      (state_d == ST_RX2) || (state_d == ST_RX3);
        out_valid_d = (state_d == ST_TX_HI) || (state_d == ST_TX_LO);
        out_data_d  = '0;
        if (state_d == ST_TX_HI) begin
            out_data_d = {RSP_PAD, cap_d[OP_W-1:BYTE_W]};
        end else if (state_d == ST_TX_LO) begin
            out_data_d = cap_d[BYTE_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RX0;
            cmd_q       <= '0;
            cap_q       <= '0;
            settle_q    <= '0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cap_q       <= cap_d;
            settle_q    <= settle_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_satadd_frame_ctrl.sv
// Self-checking bench for satadd_frame_ctrl: directed frames plus a cycle-level reference model.
module tb_satadd_frame_ctrl;

    localparam int unsigned SETTLE = 3;
    localparam int unsigned TMO    = 200;

    typedef struct packed {
        logic [1:0]  m;
        logic [11:0] a;
        logic [11:0] b;
        logic [11:0] y;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        frame_err;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int          m_rx_n = 0;
    int          m_wait = 0;
    logic [7:0]  m_buf [4];
    logic [11:0] m_rsp = '0;
    logic [7:0]  m_tx [$];
    int          m_cnt = 0;
    logic        m_err = 1'b0;

    vec_t vecs [12];

    satadd_frame_ctrl #(.SETTLE_CYCLES(SETTLE), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out after %0d cycles at %0t", name, TMO, $time);
    endtask

    function automatic logic [11:0] gold(input logic [1:0] m, input logic [11:0] a, input logic [11:0] b);
        int va, vb, r, hi, lo;
        va = (m[0] && a[11]) ? int'(a) - 4096 : int'(a);
        vb = (m[0] && b[11]) ? int'(b) - 4096 : int'(b);
        r  = m[1] ? va - vb : va + vb;
        hi = m[0] ? 2047 : 4095;
        lo = m[0] ? -2048 : 0;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return 12'(r);
    endfunction

    // Model: accepts bytes while idle, answers SETTLE+1 edges after byte3.
    initial forever begin
        logic err_nxt;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_rx_n = 0;
            m_wait = 0;
            m_tx.delete();
            m_cnt  = 0;
            m_err  = 1'b0;
        end else begin
            err_nxt = 1'b0;
            if (m_wait == 0 && m_tx.size() == 0) begin
                if (in_valid) begin
                    if (m_rx_n == 0 && in_data[7:2] != 6'd0) begin
                        err_nxt = 1'b1;
                    end else begin
                        m_buf[m_rx_n] = in_data;
                        m_rx_n++;
                        if (m_rx_n == 4) begin
                            m_rsp  = gold(m_buf[0][1:0], {m_buf[1], m_buf[2][7:4]},
                                          {m_buf[2][3:0], m_buf[3]});
                            m_rx_n = 0;
                            m_wait = SETTLE + 1;
                        end
                    end
                end
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_tx.push_back({4'h0, m_rsp[11:8]});
                    m_tx.push_back(m_rsp[7:0]);
                end
            end else if (out_ready) begin
                void'(m_tx.pop_front());
                if (m_tx.size() == 0) m_cnt = (m_cnt + 1) % 65536;
            end
            m_err = err_nxt;
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            check("in_ready", in_ready, (m_wait == 0 && m_tx.size() == 0));
            check("out_valid", out_valid, (m_tx.size() > 0));
            if (m_tx.size() > 0) check("out_data", out_data, m_tx[0]);
            check("frame_err", frame_err, m_err);
            check("frame_cnt", frame_cnt, m_cnt);
            check("half_duplex", (in_ready && out_valid), 0);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        in_valid = 1'b0;
        repeat (gap) step;
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < TMO) begin
            step;
            t++;
        end
        if (t >= TMO) timeout("in_ready_wait");
        step;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [1:0] m, input logic [11:0] a, input logic [11:0] b, input int gap);
        send_byte({6'd0, m}, gap);
        send_byte(a[11:4], gap);
        send_byte({a[3:0], b[11:8]}, gap);
        send_byte(b[7:0], gap);
    endtask

    task automatic recv_frame(output logic [11:0] y);
        logic [7:0] hi, lo;
        int t;
        out_ready = 1'b1;
        t = 0;
        while (!out_valid && t < TMO) begin
            step;
            t++;
        end
        if (t >= TMO) timeout("out_valid_hi");
        hi = out_data;
        step;
        t = 0;
        while (!out_valid && t < TMO) begin
            step;
            t++;
        end
        if (t >= TMO) timeout("out_valid_lo");
        lo = out_data;
        step;
        check("rsp_pad", hi[7:4], 0);
        y = {hi[3:0], lo};
    endtask

    initial begin
        logic [11:0] y;
        int          n;
        int          t;

        vecs[0]  = '{2'd0, 12'h123, 12'h456, 12'h579};
        vecs[1]  = '{2'd1, 12'h7FF, 12'h001, 12'h7FF};
        vecs[2]  = '{2'd0, 12'hFFF, 12'h001, 12'hFFF};
        vecs[3]  = '{2'd0, 12'h800, 12'h7FF, 12'hFFF};
        vecs[4]  = '{2'd1, 12'h800, 12'hFFF, 12'h800};
        vecs[5]  = '{2'd2, 12'h010, 12'h020, 12'h000};
        vecs[6]  = '{2'd2, 12'h500, 12'h123, 12'h3DD};
        vecs[7]  = '{2'd3, 12'h7FF, 12'hFFF, 12'h7FF};
        vecs[8]  = '{2'd3, 12'h800, 12'h001, 12'h800};
        vecs[9]  = '{2'd1, 12'h123, 12'hF00, 12'h023};
        vecs[10] = '{2'd3, 12'h100, 12'h200, 12'hF00};
        vecs[11] = '{2'd0, 12'hABC, 12'h123, 12'hBDF};

        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        rst_n = 1'b1;
        step;

        // vector replay, starting with the basic 00,12,34,56 frame
        for (int i = 0; i < 12; i++) begin
            send_frame(vecs[i].m, vecs[i].a, vecs[i].b, 0);
            recv_frame(y);
            check($sformatf("vec%0d_y", i), y, vecs[i].y);
            check($sformatf("vec%0d_cnt", i), frame_cnt, i + 1);
        end

        // malformed header then a good frame
        send_byte(8'hFC, 0);
        check("bad_hdr_err", frame_err, 1);
        check("bad_hdr_rx0", in_ready, 1);
        step;
        check("bad_hdr_err_clr", frame_err, 0);
        send_frame(vecs[0].m, vecs[0].a, vecs[0].b, 0);
        recv_frame(y);
        check("post_bad_y", y, 12'h579);
        check("post_bad_cnt", frame_cnt, 13);

        // gaps between command bytes
        send_frame(vecs[6].m, vecs[6].a, vecs[6].b, 5);
        recv_frame(y);
        check("gap_y", y, 12'h3DD);

        // backpressure in TX_HI
        out_ready = 1'b0;
        send_frame(vecs[1].m, vecs[1].a, vecs[1].b, 0);
        t = 0;
        while (!out_valid && t < TMO) begin
            step;
            t++;
        end
        if (t >= TMO) timeout("stall_valid");
        for (int i = 0; i < 10; i++) begin
            check("stall_data", out_data, 8'h07);
            check("stall_in_ready", in_ready, 0);
            step;
        end
        recv_frame(y);
        check("stall_y", y, 12'h7FF);

        // latency from byte3 handshake edge to out_valid
        send_frame(vecs[11].m, vecs[11].a, vecs[11].b, 0);
        n = 0;
        while (!out_valid && n < TMO) begin
            step;
            n++;
        end
        check("latency", n, 4);
        recv_frame(y);
        check("latency_y", y, 12'hBDF);

        // asynchronous reset while in RX2
        send_byte(8'h00, 0);
        send_byte(8'h12, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 1);
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_frame_err", frame_err, 0);
        check("arst_frame_cnt", frame_cnt, 0);
        #3;
        rst_n = 1'b1;
        step;
        send_frame(vecs[9].m, vecs[9].a, vecs[9].b, 0);
        recv_frame(y);
        check("after_rst_y", y, 12'h023);
        check("after_rst_cnt", frame_cnt, 1);

        repeat (3) step;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
